// File: rtl/pipe_out_pattern_gen.sv
// Burst-controlled pattern source for the Pipe Out FIFO write side.
// Produces count, LFSR, walking-one or alternating words at one word per accepted read.
module pipe_out_pattern_gen #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          COUNT_WIDTH = 24,
  parameter logic [31:0] LFSR_SEED   = 32'h04030201
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COUNT_WIDTH-1:0] length,
  input  logic                   pipe_out_read,
  output logic [DATA_WIDTH-1:0]  pipe_out_data,
  output logic                   pipe_out_valid,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] words_sent
);

  localparam int NL = (DATA_WIDTH + 31) / 32;
  localparam int WW = NL * 32;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q;
  logic [COUNT_WIDTH-1:0] len_q;
  logic [COUNT_WIDTH-1:0] sent_q;
  logic [WW-1:0]          word_q;
  logic [WW-1:0]          init_word;
  logic [WW-1:0]          next_word;
  logic                   done_q;
  logic                   load;
  logic                   advance;
  logic                   finish;
  logic                   accept;

  assign pipe_out_valid = (state_q == RUN);
  assign busy           = (state_q == RUN);
  assign done           = done_q;
  assign words_sent     = sent_q;
  assign pipe_out_data  = word_q[DATA_WIDTH-1:0];
  assign accept         = pipe_out_read & pipe_out_valid;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          if (len_q != '0 && sent_q == len_q - COUNT_WIDTH'(1)) begin
            state_d = IDLE;
            finish  = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Initial word is built from the live mode input since it is latched in the same edge.
  always_comb begin
    init_word = '0;
    case (mode)
      2'd0: begin
        for (int unsigned k = 0; k < NL; k++) init_word[32*k +: 32] = 32'h0000_0001;
      end
      2'd1: begin
        for (int unsigned k = 0; k < NL; k++)
          init_word[32*k +: 32] = LFSR_SEED + 32'(k) * 32'h0909_0909;
      end
      2'd2: init_word[0] = 1'b1;
      default: begin
        for (int unsigned i = 0; i < WW / 16; i++) init_word[16*i +: 16] = 16'h5555;
      end
    endcase
  end

  always_comb begin
    next_word = word_q;
    case (mode_q)
      2'd0: begin
        for (int unsigned k = 0; k < NL; k++)
          next_word[32*k +: 32] = word_q[32*k +: 32] + 32'd1;
      end
      2'd1: begin
        for (int unsigned k = 0; k < NL; k++)
          next_word[32*k +: 32] = {word_q[32*k +: 31],
                                   word_q[32*k+31] ^ word_q[32*k+21] ^ word_q[32*k+1]};
      end
      2'd2: begin
        // Rotation spans only the visible DATA_WIDTH bits, not the padded lane width.
        next_word = '0;
        next_word[DATA_WIDTH-1:0] = {word_q[DATA_WIDTH-2:0], word_q[DATA_WIDTH-1]};
      end
      default: next_word = ~word_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      sent_q  <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= finish;
      if (load) begin
        mode_q <= mode;
        len_q  <= length;
        sent_q <= '0;
        word_q <= init_word;
      end else begin
        if (accept) sent_q <= sent_q + COUNT_WIDTH'(1);
        if (advance) word_q <= next_word;
      end
    end
  end

endmodule
